// File: rtl/uart_frame_tx.sv
// uart_frame_tx: FIFO-buffered UART transmitter with runtime parity and configurable framing
module uart_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [DATA_WIDTH-1:0]         DATA_IN,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  output logic                          TX,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] sh, head;
  logic [PW-1:0]         pcnt;
  logic [BW-1:0]         bcnt;
  logic                  par_en_q, par_bit;
  logic                  push, pop, bit_end, stop_end;
  assign head = mem[rd_ptr];
  // handshake and pop decision: a frame starts from idle or straight after the last stop cycle
  always_comb begin
    DATA_READY = FIFO_COUNT != CW'(FIFO_DEPTH);
    push       = DATA_VALID && DATA_READY;
    bit_end    = pcnt == PW'(PRESCALE - 1);
    stop_end   = state == STOP && bit_end && bcnt == BW'(STOP_BITS - 1);
    pop        = FIFO_COUNT != '0 && (state == IDLE || stop_end);
  end
  // input FIFO: pointers wrap naturally since depth is a power of two
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_COUNT <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= DATA_IN;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      FIFO_COUNT <= FIFO_COUNT + CW'(push) - CW'(pop);
    end
  end
  // frame sequencer: TX is registered and changes only at bit boundaries
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      TX       <= 1'b1;
      BUSY     <= 1'b0;
      pcnt     <= '0;
      bcnt     <= '0;
      sh       <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else if (pop) begin
      state    <= START;
      TX       <= 1'b0;
      BUSY     <= 1'b1;
      pcnt     <= '0;
      bcnt     <= '0;
      sh       <= head;
      par_en_q <= PAR_EN;
      par_bit  <= ^head ^ PAR_TYP;
    end else if (state != IDLE) begin
      pcnt <= bit_end ? '0 : pcnt + 1'b1;
      if (bit_end) begin
        case (state)
          START: begin
            state <= DATA;
            TX    <= sh[0];
            sh    <= sh >> 1;
            bcnt  <= '0;
          end
          DATA: begin
            if (bcnt == BW'(DATA_WIDTH - 1)) begin
              state <= par_en_q ? PARITY : STOP;
              TX    <= par_en_q ? par_bit : 1'b1;
              bcnt  <= '0;
            end else begin
              TX   <= sh[0];
              sh   <= sh >> 1;
              bcnt <= bcnt + 1'b1;
            end
          end
          PARITY: begin
            state <= STOP;
            TX    <= 1'b1;
          end
          STOP: begin
            if (bcnt == BW'(STOP_BITS - 1)) begin
              state <= IDLE;
              BUSY  <= 1'b0;
              TX    <= 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed frame checks for the UART transmitter, default and 7-bit/2-stop instances
module tb_uart_frame_tx;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] d1 = '0;
  logic       v1 = 1'b0, pe1 = 1'b0, pt1 = 1'b0, r1, tx1, busy1;
  logic [2:0] cnt1;
  logic [6:0] d2 = '0;
  logic       v2 = 1'b0, pe2 = 1'b0, pt2 = 1'b0, r2, tx2, busy2;
  logic [2:0] cnt2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  uart_frame_tx dut1 (
    .CLK(clk), .RESET(rst), .DATA_IN(d1), .DATA_VALID(v1), .DATA_READY(r1),
    .PAR_EN(pe1), .PAR_TYP(pt1), .TX(tx1), .BUSY(busy1), .FIFO_COUNT(cnt1)
  );

  uart_frame_tx #(.DATA_WIDTH(7), .PRESCALE(4), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .CLK(clk), .RESET(rst), .DATA_IN(d2), .DATA_VALID(v2), .DATA_READY(r2),
    .PAR_EN(pe2), .PAR_TYP(pt2), .TX(tx2), .BUSY(busy2), .FIFO_COUNT(cnt2)
  );

  task automatic push1(input logic [7:0] d);
    v1 = 1'b1;
    d1 = d;
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic wait_start(input bit inst, input int maxc, output int lat);
    lat = 0;
    while ((inst ? tx2 : tx1) !== 1'b0 && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if ((inst ? tx2 : tx1) !== 1'b0) begin
      bad++;
      $display("FAIL start_timeout tx=%b exp=0", inst ? tx2 : tx1);
    end
  endtask

  task automatic check_frame(input string nm, input bit inst, input logic [8:0] d, input int dw,
                             input bit pe, input bit pb, input int sb, input int p);
    logic [15:0] fr;
    logic t, got;
    int n;
    bit ok, bok;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < dw; i++) fr[i+1] = d[i];
    if (pe) fr[dw+1] = pb;
    n = 1 + dw + int'(pe) + sb;
    bok = 1'b1;
    for (int b = 0; b < n; b++) begin
      ok = 1'b1;
      got = 1'b0;
      for (int c = 0; c < p; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        t = inst ? tx2 : tx1;
        if (t !== fr[b] && ok) begin
          ok = 1'b0;
          got = t;
        end
        if ((inst ? busy2 : busy1) !== 1'b1) bok = 1'b0;
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s bit%0d tx=%b exp=%b", nm, b, got, fr[b]);
      end
    end
    total++;
    if (!bok) begin
      bad++;
      $display("FAIL %s busy dropped during frame exp=1", nm);
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string nm, input bit inst);
    total += 2;
    if ((inst ? tx2 : tx1) !== 1'b1) begin
      bad++;
      $display("FAIL %s idle_tx got=%b exp=1", nm, inst ? tx2 : tx1);
    end
    if ((inst ? busy2 : busy1) !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_busy got=%b exp=0", nm, inst ? busy2 : busy1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 4;
    if (tx1 !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx1); end
    if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy1); end
    if (r1 !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", r1); end
    if (cnt1 !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", cnt1); end
  endtask

  task automatic test_basic;
    int lat;
    rst = 1'b0;
    @(negedge clk);
    push1(8'hA5);
    total += 2;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL basic_prebusy got=%b exp=0", busy1); end
    if (cnt1 !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", cnt1); end
    wait_start(1'b0, 20, lat);
    total++;
    if (lat != 1) begin bad++; $display("FAIL basic_latency got=%0d exp=1", lat); end
    check_frame("a5", 1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 8);
    check_idle("a5", 1'b0);
  endtask

  task automatic test_parity;
    int lat;
    pe1 = 1'b1;
    pt1 = 1'b1;
    push1(8'h4D);
    wait_start(1'b0, 20, lat);
    check_frame("odd4d", 1'b0, 9'h04D, 8, 1'b1, 1'b1, 1, 8);
    check_idle("odd4d", 1'b0);
    pt1 = 1'b0;
    push1(8'h4D);
    wait_start(1'b0, 20, lat);
    check_frame("even4d", 1'b0, 9'h04D, 8, 1'b1, 1'b0, 1, 8);
    check_idle("even4d", 1'b0);
    pe1 = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] w [6];
    int lat, waited;
    w = '{8'h11, 8'h22, 8'h3C, 8'h81, 8'hF0, 8'h5A};
    fork
      begin
        v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
          d1 = w[i];
          @(negedge clk);
        end
        d1 = w[5];
        total += 2;
        if (r1 !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", r1); end
        if (cnt1 !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", cnt1); end
        waited = 0;
        while (r1 !== 1'b1 && waited < 200) begin
          @(negedge clk);
          waited++;
        end
        total++;
        if (waited != 77) begin bad++; $display("FAIL full_release got=%0d exp=77", waited); end
        @(negedge clk);
        v1 = 1'b0;
      end
      begin
        wait_start(1'b0, 20, lat);
        for (int i = 0; i < 6; i++) check_frame($sformatf("b2b%0d", i), 1'b0, {1'b0, w[i]}, 8, 1'b0, 1'b0, 1, 8);
        check_idle("b2b", 1'b0);
      end
    join
  endtask

  task automatic test_config_isolation;
    int lat;
    pe1 = 1'b0;
    pt1 = 1'b0;
    v1 = 1'b1;
    d1 = 8'h3C;
    @(negedge clk);
    d1 = 8'h07;
    @(negedge clk);
    v1 = 1'b0;
    fork
      begin
        wait_start(1'b0, 20, lat);
        check_frame("cfg1", 1'b0, 9'h03C, 8, 1'b0, 1'b0, 1, 8);
        check_frame("cfg2", 1'b0, 9'h007, 8, 1'b1, 1'b1, 1, 8);
        check_idle("cfg", 1'b0);
      end
      begin
        repeat (40) @(negedge clk);
        pe1 = 1'b1;
      end
    join
    pe1 = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit quiet;
    v1 = 1'b1;
    d1 = 8'h81;
    @(negedge clk);
    d1 = 8'h42;
    @(negedge clk);
    d1 = 8'h24;
    @(negedge clk);
    v1 = 1'b0;
    repeat (33) @(negedge clk);
    total++;
    if (cnt1 !== 3'd2) begin bad++; $display("FAIL mid_count got=%0d exp=2", cnt1); end
    rst = 1'b1;
    @(negedge clk);
    total += 4;
    if (tx1 !== 1'b1) begin bad++; $display("FAIL mid_tx got=%b exp=1", tx1); end
    if (busy1 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy1); end
    if (cnt1 !== 3'd0) begin bad++; $display("FAIL mid_fifo got=%0d exp=0", cnt1); end
    if (r1 !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", r1); end
    rst = 1'b0;
    quiet = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL mid_quiet got=activity exp=idle"); end
  endtask

  task automatic test_stop2;
    int lat;
    v2 = 1'b1;
    d2 = 7'h55;
    @(negedge clk);
    v2 = 1'b0;
    wait_start(1'b1, 20, lat);
    total++;
    if (lat != 1) begin bad++; $display("FAIL s2_latency got=%0d exp=1", lat); end
    check_frame("s2", 1'b1, 9'h055, 7, 1'b0, 1'b0, 2, 4);
    check_idle("s2", 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_config_isolation();
    test_reset_mid();
    test_stop2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
